hfrv_retire_trace: RTL and testbench

- Synthesizable retire-trace capture buffer for the HF-RISCV core.
- Takes NUM_PORTS retired-instruction streams (pc, instruction word, writeback data) and filters them by major opcode class.
- Stores accepted entries in order in a first-word-fall-through FIFO and drains them over a valid/ready port to a UART/debug bridge or to the bench monitor.
- Counts entries lost to overflow. Replaces software-side history capture with a hardware, per-opcode-filterable trace.

---
 rtl/hfrv_retire_trace.sv | 159 +++++++++++++++
 tb/tb_hfrv_retire_trace.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/hfrv_retire_trace.sv
// Retire-trace capture FIFO: filters NUM_PORTS retire streams by opcode class into an FWFT queue.
// Define HFRV_TRACE_TIMESTAMP_EN to stamp each entry with a free-running cycle count (out_time).

module hfrv_retire_trace_lane (
    input  logic        enable,
    input  logic        valid,
    input  logic [4:0]  opcode,
    input  logic [31:0] filter_mask,
    output logic        cand
);
    assign cand = enable && valid && filter_mask[opcode];
endmodule

module hfrv_retire_trace #(
    parameter int NUM_PORTS = 1,
    parameter int DEPTH     = 16,
    parameter int DROP_W    = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          clear,
    input  logic [31:0]                   filter_mask,
    input  logic [NUM_PORTS-1:0]          ret_valid,
    input  logic [NUM_PORTS*32-1:0]       ret_pc,
    input  logic [NUM_PORTS*32-1:0]       ret_instr,
    input  logic [NUM_PORTS*32-1:0]       ret_wdata,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_pc,
    output logic [31:0]                   out_instr,
    output logic [31:0]                   out_wdata,
`ifdef HFRV_TRACE_TIMESTAMP_EN
    output logic [31:0]                   out_time,
`endif
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic [DROP_W-1:0]             drop_count,
    output logic                          overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(NUM_PORTS+1);

    typedef struct packed {
`ifdef HFRV_TRACE_TIMESTAMP_EN
        logic [31:0] stamp;
`endif
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] wdata;
    } entry_t;

    entry_t                        mem [DEPTH];
    entry_t                        entry_in [NUM_PORTS];
    entry_t                        head;
    logic [NUM_PORTS-1:0]          cand;
    logic [NUM_PORTS-1:0]          wen;
    logic [NUM_PORTS-1:0][PW-1:0]  rank;
    logic [AW-1:0]                 wr_ptr, rd_ptr;
    logic [CW-1:0]                 count_q;
    logic [CW:0]                   space;
    logic [PW-1:0]                 ncand, npush, ndrop;
    logic [DROP_W:0]               dsum;
    logic [DROP_W-1:0]             drop_next;
    logic                          pop;
`ifdef HFRV_TRACE_TIMESTAMP_EN
    logic [31:0]                   tstamp;
`endif

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_lane
        hfrv_retire_trace_lane u_lane (
            .enable      (enable),
            .valid       (ret_valid[g]),
            .opcode      (ret_instr[32*g+2 +: 5]),
            .filter_mask (filter_mask),
            .cand        (cand[g])
        );
        assign entry_in[g].pc    = ret_pc[32*g +: 32];
        assign entry_in[g].instr = ret_instr[32*g +: 32];
        assign entry_in[g].wdata = ret_wdata[32*g +: 32];
`ifdef HFRV_TRACE_TIMESTAMP_EN
        assign entry_in[g].stamp = tstamp;
`endif
    end

    // Candidates take consecutive slots in port order; once space runs out every later one drops.
    always_comb begin
        pop   = out_valid && out_ready;
        space = (CW+1)'(DEPTH) - (CW+1)'(count_q) + (CW+1)'(pop);
        ncand = '0;
        npush = '0;
        wen   = '0;
        rank  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            rank[i] = ncand;
            if (cand[i] && !clear) begin
                if ((CW+1)'(ncand) < space) begin
                    wen[i] = 1'b1;
                    npush  = npush + PW'(1);
                end
                ncand = ncand + PW'(1);
            end
        end
        ndrop     = ncand - npush;
        dsum      = (DROP_W+1)'(drop_count) + (DROP_W+1)'(ndrop);
        drop_next = dsum[DROP_W] ? '1 : dsum[DROP_W-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
`ifdef HFRV_TRACE_TIMESTAMP_EN
            tstamp     <= '0;
`endif
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
`ifdef HFRV_TRACE_TIMESTAMP_EN
            tstamp     <= '0;
`endif
        end else begin
            wr_ptr     <= wr_ptr + AW'(npush);
            count_q    <= count_q + CW'(npush) - CW'(pop);
            drop_count <= drop_next;
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (ndrop != '0)
                overflow <= 1'b1;
`ifdef HFRV_TRACE_TIMESTAMP_EN
            tstamp     <= tstamp + 32'd1;
`endif
        end
    end

    // Storage is deliberately not reset; out_* masking hides stale slots.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PORTS; i++)
            if (wen[i])
                mem[wr_ptr + AW'(rank[i])] <= entry_in[i];
    end

    assign head      = mem[rd_ptr];
    assign count     = count_q;
    assign out_valid = (count_q != '0);
    assign out_pc    = out_valid ? head.pc    : '0;
    assign out_instr = out_valid ? head.instr : '0;
    assign out_wdata = out_valid ? head.wdata : '0;
`ifdef HFRV_TRACE_TIMESTAMP_EN
    assign out_time  = out_valid ? head.stamp : '0;
`endif

endmodule

// File: tb/tb_hfrv_retire_trace.sv
// Bench for hfrv_retire_trace: directed vector table, async-reset sequence, then random traffic vs a queue model.

module tb_hfrv_retire_trace;
    localparam int NP = 2;
    localparam int D  = 4;
    localparam int DW = 4;
    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] ADD  = 32'h002081B3;
    localparam logic [31:0] ALL  = 32'hFFFFFFFF;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            enable, clear, out_ready, out_valid, overflow;
    logic [31:0]     filter_mask, out_pc, out_instr, out_wdata;
    logic [NP-1:0]   ret_valid;
    logic [NP*32-1:0] ret_pc, ret_instr, ret_wdata;
    logic [2:0]      count;
    logic [DW-1:0]   drop_count;
`ifdef HFRV_TRACE_TIMESTAMP_EN
    logic [31:0]     out_time;
`endif

    int checks = 0;
    int errors = 0;

    hfrv_retire_trace #(.NUM_PORTS(NP), .DEPTH(D), .DROP_W(DW)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
        .filter_mask(filter_mask), .ret_valid(ret_valid), .ret_pc(ret_pc),
        .ret_instr(ret_instr), .ret_wdata(ret_wdata), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .out_wdata(out_wdata),
`ifdef HFRV_TRACE_TIMESTAMP_EN
        .out_time(out_time),
`endif
        .count(count), .drop_count(drop_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] wd(input logic [31:0] pc);
        return {16'h0, pc[15:0]} + 32'd5;
    endfunction

    task automatic drive(input logic rdy, input logic en, input logic clr, input logic [31:0] mask,
                         input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] in0,
                         input logic [31:0] pc1, input logic [31:0] in1);
        out_ready   = rdy;
        enable      = en;
        clear       = clr;
        filter_mask = mask;
        ret_valid   = v;
        ret_pc      = {pc1, pc0};
        ret_instr   = {in1, in0};
        ret_wdata   = {wd(pc1), wd(pc0)};
    endtask

    // Expected values describe the state after the edge on which the inputs were applied.
    typedef struct {
        logic rdy, en, clr;
        logic [31:0] mask;
        logic [1:0]  v;
        logic [31:0] pc0, in0, pc1;
        logic        ev;
        logic [31:0] epc, ein;
        int          ecnt, edrop;
        logic        eovf;
    } vec_t;

    function automatic vec_t mk(input logic rdy, input logic en, input logic clr, input logic [31:0] mask,
                                input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] in0,
                                input logic [31:0] pc1, input logic ev, input logic [31:0] epc,
                                input logic [31:0] ein, input int ecnt, input int edrop, input logic eovf);
        vec_t r;
        r.rdy = rdy; r.en = en; r.clr = clr; r.mask = mask; r.v = v;
        r.pc0 = pc0; r.in0 = in0; r.pc1 = pc1;
        r.ev = ev; r.epc = epc; r.ein = ein; r.ecnt = ecnt; r.edrop = edrop; r.eovf = eovf;
        return r;
    endfunction

    typedef struct {
        logic [31:0] pc, instr, wdata, stamp;
    } ent_t;

    ent_t        mq[$];
    int          mdrop;
    bit          movf;
    logic [31:0] mtime;

    task automatic model_check(input int cyc);
        chk($sformatf("rnd%0d valid", cyc), 32'(out_valid), 32'(mq.size() != 0));
        chk($sformatf("rnd%0d count", cyc), 32'(count), 32'(mq.size()));
        chk($sformatf("rnd%0d drop", cyc), 32'(drop_count), 32'(mdrop));
        chk($sformatf("rnd%0d ovf", cyc), 32'(overflow), 32'(movf));
        chk($sformatf("rnd%0d pc", cyc), out_pc, mq.size() != 0 ? mq[0].pc : 32'h0);
        chk($sformatf("rnd%0d instr", cyc), out_instr, mq.size() != 0 ? mq[0].instr : 32'h0);
        chk($sformatf("rnd%0d wdata", cyc), out_wdata, mq.size() != 0 ? mq[0].wdata : 32'h0);
`ifdef HFRV_TRACE_TIMESTAMP_EN
        chk($sformatf("rnd%0d time", cyc), out_time, mq.size() != 0 ? mq[0].stamp : 32'h0);
`endif
    endtask

    // One clock edge of the trace buffer described as queue operations on the current inputs.
    task automatic model_step();
        int   space;
        bit   pop;
        ent_t e;
        ent_t added[$];
        if (clear) begin
            mq.delete();
            mdrop = 0;
            movf  = 0;
            mtime = 0;
            return;
        end
        pop   = (mq.size() != 0) && out_ready;
        space = D - mq.size() + int'(pop);
        for (int p = 0; p < NP; p++) begin
            e.instr = ret_instr[32*p +: 32];
            if (enable && ret_valid[p] && filter_mask[e.instr[6:2]]) begin
                if (space > 0) begin
                    e.pc    = ret_pc[32*p +: 32];
                    e.wdata = ret_wdata[32*p +: 32];
                    e.stamp = mtime;
                    added.push_back(e);
                    space--;
                end else begin
                    mdrop = (mdrop + 1 > (1 << DW) - 1) ? (1 << DW) - 1 : mdrop + 1;
                    movf  = 1;
                end
            end
        end
        if (pop)
            void'(mq.pop_front());
        foreach (added[k])
            mq.push_back(added[k]);
        mtime = mtime + 32'd1;
    endtask

    vec_t tbl[$];

    initial begin
        tbl.push_back(mk(0,1,0,ALL,2'b01,32'h40000000,ADDI,0, 1,32'h40000000,ADDI,1,0,0));
        tbl.push_back(mk(1,1,0,ALL,2'b00,0,ADDI,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,1,0,32'h10,2'b01,32'h100,32'h00100093,0, 1,32'h100,32'h00100093,1,0,0));
        tbl.push_back(mk(0,1,0,32'h10,2'b01,32'h104,ADD,0, 1,32'h100,32'h00100093,1,0,0));
        tbl.push_back(mk(1,1,0,32'h10,2'b00,0,ADDI,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,1,0,ALL,2'b01,32'h200,ADDI,0, 1,32'h200,ADDI,1,0,0));
        tbl.push_back(mk(0,1,0,ALL,2'b01,32'h204,ADDI,0, 1,32'h200,ADDI,2,0,0));
        tbl.push_back(mk(0,1,0,ALL,2'b01,32'h208,ADDI,0, 1,32'h200,ADDI,3,0,0));
        tbl.push_back(mk(0,1,0,ALL,2'b01,32'h20C,ADDI,0, 1,32'h200,ADDI,4,0,0));
        tbl.push_back(mk(0,1,0,ALL,2'b01,32'h210,ADDI,0, 1,32'h200,ADDI,4,1,1));
        tbl.push_back(mk(0,1,0,ALL,2'b01,32'h214,ADDI,0, 1,32'h200,ADDI,4,2,1));
        tbl.push_back(mk(1,1,0,ALL,2'b00,0,ADDI,0, 1,32'h204,ADDI,3,2,1));
        tbl.push_back(mk(1,1,0,ALL,2'b00,0,ADDI,0, 1,32'h208,ADDI,2,2,1));
        tbl.push_back(mk(1,1,0,ALL,2'b00,0,ADDI,0, 1,32'h20C,ADDI,1,2,1));
        tbl.push_back(mk(1,1,0,ALL,2'b00,0,ADDI,0, 0,0,0,0,2,1));
        tbl.push_back(mk(0,1,0,ALL,2'b11,32'h300,ADDI,32'h304, 1,32'h300,ADDI,2,2,1));
        tbl.push_back(mk(0,1,0,ALL,2'b01,32'h308,ADDI,0, 1,32'h300,ADDI,3,2,1));
        tbl.push_back(mk(0,1,0,ALL,2'b11,32'h30C,ADDI,32'h310, 1,32'h300,ADDI,4,3,1));
        tbl.push_back(mk(1,1,0,ALL,2'b00,0,ADDI,0, 1,32'h304,ADDI,3,3,1));
        tbl.push_back(mk(1,1,0,ALL,2'b11,32'h318,ADDI,32'h31C, 1,32'h308,ADDI,4,3,1));
        tbl.push_back(mk(1,1,0,ALL,2'b11,32'h320,ADDI,32'h324, 1,32'h30C,ADDI,4,4,1));
        tbl.push_back(mk(0,0,0,ALL,2'b11,32'h330,ADDI,32'h334, 1,32'h30C,ADDI,4,4,1));
        tbl.push_back(mk(1,1,1,ALL,2'b11,32'h340,ADDI,32'h344, 0,0,0,0,0,0));
        tbl.push_back(mk(0,1,0,ALL,2'b10,0,ADDI,32'h350, 1,32'h350,ADDI,1,0,0));
        tbl.push_back(mk(0,1,0,ALL,2'b11,32'h360,ADDI,32'h364, 1,32'h350,ADDI,3,0,0));
        tbl.push_back(mk(0,1,0,ALL,2'b11,32'h368,ADDI,32'h36C, 1,32'h350,ADDI,4,1,1));

        reset_n = 1'b0;
        drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        #12;
        chk("reset valid", 32'(out_valid), 32'h0);
        chk("reset count", 32'(count), 32'h0);
        chk("reset drop", 32'(drop_count), 32'h0);
        chk("reset ovf", 32'(overflow), 32'h0);
        chk("reset pc", out_pc, 32'h0);
        #8 reset_n = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            drive(tbl[i].rdy, tbl[i].en, tbl[i].clr, tbl[i].mask, tbl[i].v,
                  tbl[i].pc0, tbl[i].in0, tbl[i].pc1, tbl[i].in0);
            @(posedge clk); #1;
            chk($sformatf("vec%0d valid", i), 32'(out_valid), 32'(tbl[i].ev));
            chk($sformatf("vec%0d pc", i), out_pc, tbl[i].epc);
            chk($sformatf("vec%0d instr", i), out_instr, tbl[i].ein);
            chk($sformatf("vec%0d wdata", i), out_wdata, tbl[i].ev ? wd(tbl[i].epc) : 32'h0);
            chk($sformatf("vec%0d count", i), 32'(count), 32'(tbl[i].ecnt));
            chk($sformatf("vec%0d drop", i), 32'(drop_count), 32'(tbl[i].edrop));
            chk($sformatf("vec%0d ovf", i), 32'(overflow), 32'(tbl[i].eovf));
        end

        // Asynchronous reset pulse between edges with a full FIFO.
        drive(0, 1, 0, ALL, 2'b00, 0, ADDI, 0, ADDI);
        #1 reset_n = 1'b0;
        #1;
        chk("areset valid", 32'(out_valid), 32'h0);
        chk("areset count", 32'(count), 32'h0);
        chk("areset drop", 32'(drop_count), 32'h0);
        chk("areset ovf", 32'(overflow), 32'h0);
        chk("areset pc", out_pc, 32'h0);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;

        mq.delete();
        mdrop = 0;
        movf  = 0;
        mtime = 32'd1;
        for (int c = 0; c < 800; c++) begin
            logic [31:0] m;
            model_check(c);
            m = ($urandom_range(0, 1) == 1) ? ALL : $urandom;
            drive(((c / 100) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 7) != 0, $urandom_range(0, 63) == 0, m,
                  2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom);
            model_step();
            @(posedge clk); #1;
        end
        model_check(800);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
